// File: rtl/frame_drain_pkg.sv
// Shared geometry constants and state type for the 3x3 filter result path.
// The window engine imports this package as well.
package frame_pkg;

   localparam int unsigned WIDTH        = 256;
   localparam int unsigned HEIGHT       = 32;
   localparam int unsigned PIX_W        = 8;
   localparam int unsigned FRAME_PIXELS = WIDTH * HEIGHT;
   localparam int unsigned ADDR_W       = 13;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_e;

endpackage

// File: rtl/frame_drain_if.sv
// Result write port plus drained output stream of frame_drain.
interface frame_drain_if #(
   parameter int unsigned PIX_W = frame_pkg::PIX_W
);
   logic             wr;
   logic [PIX_W-1:0] pixelw;
   logic             out_ready;
   logic             out_valid;
   logic [PIX_W-1:0] out_pixel;
   logic             out_sol;
   logic             out_eol;
   logic             out_eof;
   logic             busy;
   logic             overflow;

   modport master (
      output wr, pixelw, out_ready,
      input  out_valid, out_pixel, out_sol, out_eol, out_eof, busy, overflow
   );

   modport slave (
      input  wr, pixelw, out_ready,
      output out_valid, out_pixel, out_sol, out_eol, out_eof, busy, overflow
   );

endinterface

// File: rtl/frame_ram_sdp.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The array carries no reset; contents survive rst_n.
module frame_ram_sdp #(
   parameter int unsigned DEPTH  = 8192,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/frame_drain.sv
// Captures one filtered frame into the buffer, then streams it out in raster
// order over valid/ready with line/frame markers.
module frame_drain #(
   parameter int unsigned WIDTH  = frame_pkg::WIDTH,
   parameter int unsigned HEIGHT = frame_pkg::HEIGHT,
   parameter int unsigned PIX_W  = frame_pkg::PIX_W
) (
   input  logic         clk,
   input  logic         rst_n,
   frame_drain_if.slave bus
);
   import frame_pkg::*;

   localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
   localparam int unsigned AW        = $clog2(FRAME_PIX);
   localparam int unsigned COL_W     = $clog2(WIDTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);

   state_e           state_q, state_d;
   logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
   logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             overflow_q, overflow_d;
   logic             ram_we;
   logic             handshake;
   logic [PIX_W-1:0] ram_rdata;
   logic [COL_W-1:0] col;

   assign handshake = out_valid_q && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      out_valid_d = out_valid_q;
      overflow_d  = overflow_q;
      ram_we      = 1'b0;
      unique case (state_q)
         FILL: begin
            out_valid_d = 1'b0;
            if (bus.wr) begin
               ram_we = 1'b1;
               if (wr_cnt_q == LAST_ADDR) begin
                  wr_cnt_d = '0;
                  state_d  = DRAIN;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            // First DRAIN cycle only primes the RAM read of address 0.
            out_valid_d = 1'b1;
            if (bus.wr) begin
               overflow_d = 1'b1;
            end
            if (handshake) begin
               if (rd_cnt_q == LAST_ADDR) begin
                  rd_cnt_d    = '0;
                  out_valid_d = 1'b0;
                  state_d     = FILL;
               end else begin
                  rd_cnt_d = rd_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   // Reading at rd_cnt_d keeps data steady under backpressure and sustains
   // one beat per cycle when ready is held high.
   frame_ram_sdp #(
      .DEPTH  (FRAME_PIX),
      .DATA_W (PIX_W),
      .ADDR_W (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_cnt_q),
      .wdata (bus.pixelw),
      .raddr (rd_cnt_d),
      .rdata (ram_rdata)
   );

   assign col = rd_cnt_q[COL_W-1:0];

   assign bus.out_valid = out_valid_q;
   assign bus.out_pixel = out_valid_q ? ram_rdata : '0;
   assign bus.out_sol   = out_valid_q && (col == '0);
   assign bus.out_eol   = out_valid_q && (col == '1);
   assign bus.out_eof   = out_valid_q && (rd_cnt_q == LAST_ADDR);
   assign bus.busy      = (state_q != FILL);
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_frame_drain.sv
// Self-checking bench for frame_drain: spot-check table, reference frame model,
// random backpressure, overflow and asynchronous reset sequences.
module tb_frame_drain;

   // Full row width, reduced frame height to keep the run short.
   localparam int unsigned TW     = 256;
   localparam int unsigned TH     = 4;
   localparam int unsigned FP     = TW * TH;
   localparam int unsigned BUDGET = 20 * FP;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   frame_drain_if #(.PIX_W(8)) bus ();

   frame_drain #(
      .WIDTH  (TW),
      .HEIGHT (TH),
      .PIX_W  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] frame_m [FP];
   bit         ovf_m;
   logic [7:0] got_pix [FP];
   bit         got_sol [FP];
   bit         got_eol [FP];
   bit         got_eof [FP];

   typedef struct {
      int         beat;
      logic [7:0] pix;
      bit         sol;
      bit         eol;
      bit         eof;
   } spot_t;

   spot_t spots [7];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, bus.out_valid, 0);
      chk({tag, "_pixel"}, bus.out_pixel, 0);
      chk({tag, "_markers"}, {bus.out_sol, bus.out_eol, bus.out_eof}, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_overflow"}, bus.overflow, 0);
   endtask

   // mode 0: ascending ramp from base, 1: constant 0xA5, 2: descending ramp, else random
   task automatic fill_frame(input int mode, input int base, input int gap, input int n);
      logic [7:0] p;
      for (int a = 0; a < n; a++) begin
         case (mode)
            0:       p = 8'(a + base);
            1:       p = 8'hA5;
            2:       p = 8'(base - a);
            default: p = 8'($urandom);
         endcase
         chk("busy_in_fill", bus.busy, 0);
         frame_m[a] = p;
         bus.wr     = 1'b1;
         bus.pixelw = p;
         step();
         bus.wr     = 1'b0;
         bus.pixelw = 8'($urandom);
         if (a < n - 1) repeat (gap) step();
      end
      if (n == int'(FP)) begin
         chk("busy_after_last_wr", bus.busy, 1);
         chk("valid_after_last_wr", bus.out_valid, 0);
         step();
         chk("valid_latency", bus.out_valid, 1);
         chk("first_pixel", bus.out_pixel, frame_m[0]);
         chk("first_sol", bus.out_sol, 1);
      end
   endtask

   task automatic drain_frame(input bit rand_ready, input bit wr_pulses, input bit capture,
                              input int stop_at);
      int          beat = 0;
      int          cyc = 0;
      int          valid_cyc = 0;
      bit          stalled = 1'b0;
      bit          rdy, hs, w;
      logic [11:0] prev = '0;
      while (beat < stop_at && cyc < int'(BUDGET)) begin
         if (stalled)
            chk("stall_hold", {bus.out_valid, bus.out_pixel, bus.out_sol, bus.out_eol, bus.out_eof},
                prev);
         if (bus.out_valid) begin
            valid_cyc++;
            chk("pixel", bus.out_pixel, frame_m[beat]);
            chk("markers", {bus.out_sol, bus.out_eol, bus.out_eof},
                {beat % TW == 0, beat % TW == TW - 1, beat == FP - 1});
            if (capture) begin
               got_pix[beat] = bus.out_pixel;
               got_sol[beat] = bus.out_sol;
               got_eol[beat] = bus.out_eol;
               got_eof[beat] = bus.out_eof;
            end
         end
         rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         hs  = bus.out_valid && rdy;
         w   = wr_pulses && (($urandom_range(0, 9) == 0) || (hs && beat == FP - 1));
         if (w) ovf_m = 1'b1;
         stalled = bus.out_valid && !rdy;
         prev    = {bus.out_valid, bus.out_pixel, bus.out_sol, bus.out_eol, bus.out_eof};
         bus.out_ready = rdy;
         bus.wr        = w;
         bus.pixelw    = 8'($urandom);
         step();
         cyc++;
         if (hs) beat++;
      end
      bus.wr = 1'b0;
      if (stop_at == int'(FP)) begin
         chk("drain_beats", beat, FP);
         if (!rand_ready) begin
            chk("drain_cycles", cyc, FP);
            chk("drain_valid_cycles", valid_cyc, FP);
         end
         chk("end_valid", bus.out_valid, 0);
         chk("end_busy", bus.busy, 0);
         chk("end_markers", {bus.out_sol, bus.out_eol, bus.out_eof}, 0);
         chk("end_overflow", bus.overflow, ovf_m);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wr        = 1'b0;
      bus.pixelw    = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      ovf_m         = 1'b0;

      spots[0] = '{0,             8'd0,   1'b1, 1'b0, 1'b0};
      spots[1] = '{1,             8'd1,   1'b0, 1'b0, 1'b0};
      spots[2] = '{255,           8'd255, 1'b0, 1'b1, 1'b0};
      spots[3] = '{256,           8'd0,   1'b1, 1'b0, 1'b0};
      spots[4] = '{700,           8'd188, 1'b0, 1'b0, 1'b0};
      spots[5] = '{int'(FP) - 256, 8'd0,  1'b1, 1'b0, 1'b0};
      spots[6] = '{int'(FP) - 1,  8'd255, 1'b0, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      // Ramp frame, ready held high, captured for the spot table.
      fill_frame(0, 0, 0, FP);
      drain_frame(1'b0, 1'b0, 1'b1, FP);
      for (int i = 0; i < 7; i++) begin
         chk("spot_pixel", got_pix[spots[i].beat], spots[i].pix);
         chk("spot_markers", {got_sol[spots[i].beat], got_eol[spots[i].beat], got_eof[spots[i].beat]},
             {spots[i].sol, spots[i].eol, spots[i].eof});
      end

      // Random backpressure with stray writes, one on the final handshake.
      fill_frame(0, 0, 0, FP);
      drain_frame(1'b1, 1'b1, 1'b0, FP);
      chk("overflow_set", bus.overflow, 1);

      // Next frame begins in the cycle right after the final handshake.
      fill_frame(3, 0, 0, FP);
      chk("overflow_sticky", bus.overflow, 1);
      drain_frame(1'b0, 1'b0, 1'b0, FP);

      // Reset part-way through a fill, then a constant frame.
      fill_frame(3, 0, 0, 700);
      rst_n = 1'b0;
      ovf_m = 1'b0;
      #1;
      check_reset_outputs("rst_fill");
      step();
      rst_n = 1'b1;
      step();
      fill_frame(1, 0, 0, FP);
      chk("overflow_after_rst", bus.overflow, 0);
      drain_frame(1'b0, 1'b0, 1'b0, FP);

      // Asynchronous reset at drain beat 100, then a fresh frame from address 0.
      fill_frame(3, 0, 0, FP);
      drain_frame(1'b0, 1'b0, 1'b0, 100);
      chk("beat100_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_drain");
      step();
      rst_n = 1'b1;
      step();
      fill_frame(3, 0, 0, FP);
      drain_frame(1'b1, 1'b0, 1'b0, FP);

      // Two back-to-back sparse frames with different ramps.
      fill_frame(0, 7, 2, FP);
      drain_frame(1'b1, 1'b0, 1'b0, FP);
      fill_frame(2, 200, 2, FP);
      drain_frame(1'b1, 1'b0, 1'b0, FP);
      chk("overflow_clean", bus.overflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
